// File: rtl/uart_defs.sv
// Shared UART definitions used by the receiver and the matching transmitter.
// Contents:
//   uart_state_e    - 3-bit FSM state encoding for the serial receiver
//   PAR_EVEN/PAR_ODD - parity select constants
//   CLK_DIV_DEFAULT - default clk cycles per serial bit
package uart_defs;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  localparam int PAR_EVEN        = 0;
  localparam int PAR_ODD         = 1;
  localparam int CLK_DIV_DEFAULT = 16;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO for uart_rx: synchronous, show-ahead, DEPTH x WIDTH.
// Ports:
//   clk, reset (async, active-low)
//   push/din  - write request and data; accepted when not full, or when
//               a pop happens in the same cycle
//   pop       - remove head; ignored while empty
//   dout      - current head, forced to 0 while empty
//   full, empty
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx.sv
// Serial receiver: samples an asynchronous 8N1-style line (optional parity),
// reassembles frames LSB first and buffers them in a small show-ahead FIFO.
// Ports:
//   clk, reset (async, active-low)
//   ser_rxd    - serial line, idle high, asynchronous to clk
//   rd_en      - pop FIFO head (ignored while rx_valid=0)
//   rx_data    - FIFO head, 0 when empty
//   rx_valid   - FIFO not empty
//   frame_err  - 1-cycle pulse, stop bit sampled low
//   parity_err - 1-cycle pulse, parity mismatch on an otherwise good frame
//   overrun    - 1-cycle pulse, good byte dropped because the FIFO was full
//   busy       - receiver FSM not idle
module uart_rx
  import uart_defs::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = PAR_EVEN,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ser_rxd,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLK_DIV/2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
    // Total ones over data+parity must be odd for odd parity, even otherwise.
    return (^{d, p}) != (PARITY_ODD != 0);
  endfunction

  uart_state_e          state, state_nxt;
  logic [TW-1:0]        timer, timer_nxt;
  logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par_bad, par_bad_nxt;
  logic                 rxd_meta, rxd_s;
  logic                 push;
  logic                 fifo_full, fifo_empty;

  // Input synchronizer; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= ser_rxd;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      par_bad <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_cnt <= bit_cnt_nxt;
      par_bad <= par_bad_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer + 1'b1;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    par_bad_nxt = par_bad;
    push        = 1'b0;
    frame_err   = 1'b0;
    parity_err  = 1'b0;
    case (state)
      ST_IDLE: begin
        timer_nxt   = '0;
        bit_cnt_nxt = '0;
        par_bad_nxt = 1'b0;
        if (!rxd_s) state_nxt = ST_START;
      end
      ST_START: begin
        // Half a bit after the falling edge: still low means a real start bit.
        if (timer == HALF_LAST) begin
          timer_nxt = '0;
          state_nxt = rxd_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (timer == FULL_LAST) begin
          timer_nxt = '0;
          shreg_nxt = {rxd_s, shreg[DATA_BITS-1:1]};
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_nxt = '0;
            state_nxt   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (timer == FULL_LAST) begin
          timer_nxt   = '0;
          par_bad_nxt = parity_bad(shreg, rxd_s);
          state_nxt   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (timer == FULL_LAST) begin
          timer_nxt = '0;
          if (rxd_s) begin
            parity_err = par_bad;
            push       = ~par_bad;
            state_nxt  = ST_IDLE;
          end else begin
            // A framing error hides any parity result for the same frame.
            frame_err = 1'b1;
            state_nxt = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        timer_nxt = '0;
        if (rxd_s) state_nxt = ST_IDLE;
      end
      default: begin
        timer_nxt = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (rd_en),
    .din   (shreg),
    .dout  (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid = ~fifo_empty;
  // When full, rd_en always pops (rx_valid=1), which makes room for the push.
  assign overrun  = push & fifo_full & ~rd_en;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int BIT_T = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       ser_a, ser_p, rd_a, rd_p;
  logic [7:0] rxd_a, rxd_p;
  logic       rxv_a, rxv_p, fe_a, fe_p, pe_a, pe_p, ov_a, ov_p, busy_a, busy_p;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;
  int rise_cyc = -1;
  logic prev_v = 1'b0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int pfe_cnt = 0, pov_cnt = 0, ppe_cnt = 0;
  int exp_fe = 0, exp_ov = 0, exp_pe = 0;

  logic [7:0] qa[$];
  logic [7:0] qp[$];

  always #5 clk = ~clk;

  uart_rx #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .ser_rxd(ser_a), .rd_en(rd_a), .rx_data(rxd_a),
    .rx_valid(rxv_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a), .busy(busy_a));

  uart_rx #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut_p (
    .clk(clk), .reset(reset), .ser_rxd(ser_p), .rd_en(rd_p), .rx_data(rxd_p),
    .rx_valid(rxv_p), .frame_err(fe_p), .parity_err(pe_p), .overrun(ov_p), .busy(busy_p));

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fe_a) fe_cnt <= fe_cnt + 1;
    if (ov_a) ov_cnt <= ov_cnt + 1;
    if (pe_a) pe_cnt <= pe_cnt + 1;
    if (fe_p) pfe_cnt <= pfe_cnt + 1;
    if (ov_p) pov_cnt <= pov_cnt + 1;
    if (pe_p) ppe_cnt <= ppe_cnt + 1;
    if (rxv_a && !prev_v) rise_cyc <= cyc;
    prev_v <= rxv_a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ones(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return n;
  endfunction

  task automatic drive(input bit p, input logic v);
    if (p) ser_p = v;
    else   ser_a = v;
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic send_frame(input bit p, input logic [7:0] d, input bit with_par,
                            input logic pbit, input logic stopb);
    last_fall = cyc;
    drive(p, 1'b0);
    repeat (BIT_T) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      drive(p, d[i]);
      repeat (BIT_T) @(posedge clk);
      #1;
    end
    if (with_par) begin
      drive(p, pbit);
      repeat (BIT_T) @(posedge clk);
      #1;
    end
    drive(p, stopb);
    repeat (BIT_T) @(posedge clk);
    #1;
  endtask

  // Reference outcome of a frame on the no-parity receiver with no concurrent read.
  task automatic model_a(input logic [7:0] d, input logic stopb);
    if (!stopb) exp_fe++;
    else if (qa.size() < 4) qa.push_back(d);
    else exp_ov++;
  endtask

  task automatic model_p(input logic [7:0] d, input logic pbit);
    if (((ones(d) + int'(pbit)) % 2) != 0) exp_pe++;
    else qp.push_back(d);
  endtask

  task automatic read_chk(input bit p, input string tag);
    logic [7:0] exp;
    @(negedge clk);
    if (p) begin
      exp = qp.pop_front();
      chk({tag, "_valid"}, 32'(rxv_p), 32'd1);
      chk(tag, 32'(rxd_p), 32'(exp));
      rd_p = 1'b1;
    end else begin
      exp = qa.pop_front();
      chk({tag, "_valid"}, 32'(rxv_a), 32'd1);
      chk(tag, 32'(rxd_a), 32'(exp));
      rd_a = 1'b1;
    end
    @(posedge clk);
    #1;
    rd_a = 1'b0;
    rd_p = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       pb;
    ser_a = 1'b1; ser_p = 1'b1; rd_a = 1'b0; rd_p = 1'b0; reset = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rxv_a), 32'd0);
    chk("rst_data", 32'(rxd_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_pulses", 32'({fe_a, pe_a, ov_a}), 32'd0);
    @(posedge clk); #1; reset = 1'b1;
    repeat (4) @(posedge clk); #1;

    // 0xA5: latency and single read
    fork
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        repeat (40) @(negedge clk);
        chk("a5_busy", 32'(busy_a), 32'd1);
        chk("a5_valid_early", 32'(rxv_a), 32'd0);
      end
    join
    model_a(8'hA5, 1'b1);
    repeat (2) @(posedge clk); #1;
    chk("a5_latency", 32'(rise_cyc - last_fall), 32'd155);
    read_chk(1'b0, "a5_data");
    @(negedge clk);
    chk("a5_empty_after_rd", 32'(rxv_a), 32'd0);
    @(posedge clk); #1;

    // random bytes back-to-back
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom);
      model_a(d, 1'b1);
      send_frame(1'b0, d, 1'b0, 1'b0, 1'b1);
    end
    repeat (4) @(posedge clk); #1;
    while (qa.size() > 0) read_chk(1'b0, "rand_data");

    // 3-cycle glitch
    ser_a = 1'b0;
    repeat (3) @(posedge clk); #1;
    ser_a = 1'b1;
    repeat (30) @(posedge clk); #1;
    chk("glitch_valid", 32'(rxv_a), 32'd0);
    chk("glitch_busy", 32'(busy_a), 32'd0);
    chk("glitch_ferr", 32'(fe_cnt), 32'(exp_fe));

    // framing error with long break, then a good frame
    model_a(8'h3C, 1'b0);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (40 * BIT_T) @(posedge clk); #1;
    chk("brk_busy_low", 32'(busy_a), 32'd1);
    ser_a = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("brk_ferr_count", 32'(fe_cnt), 32'(exp_fe));
    chk("brk_no_push", 32'(rxv_a), 32'd0);
    chk("brk_idle", 32'(busy_a), 32'd0);
    model_a(8'h81, 1'b1);
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk); #1;
    read_chk(1'b0, "after_brk_data");

    // overrun on fifth byte
    for (int v = 1; v <= 5; v++) begin
      model_a(8'(v), 1'b1);
      send_frame(1'b0, 8'(v), 1'b0, 1'b0, 1'b1);
    end
    repeat (3) @(posedge clk); #1;
    chk("ovr_count", 32'(ov_cnt), 32'(exp_ov));
    chk("ovr_ferr", 32'(fe_cnt), 32'(exp_fe));
    while (qa.size() > 0) read_chk(1'b0, "ovr_data");

    // full FIFO, pop in the push cycle of 0x77
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      model_a(d, 1'b1);
      send_frame(1'b0, d, 1'b0, 1'b0, 1'b1);
    end
    fork
      send_frame(1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        rd_a = 1'b1;
        @(negedge clk);
        chk("pp_head", 32'(rxd_a), 32'(qa[0]));
        chk("pp_no_ovr_pulse", 32'(ov_a), 32'd0);
        @(posedge clk);
        #1;
        rd_a = 1'b0;
      end
    join
    void'(qa.pop_front());
    qa.push_back(8'h77);
    repeat (3) @(posedge clk); #1;
    chk("pp_ovr_count", 32'(ov_cnt), 32'(exp_ov));
    while (qa.size() > 0) read_chk(1'b0, "pp_data");

    // even parity receiver
    model_p(8'h07, 1'b0);
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("par_err_count", 32'(ppe_cnt), 32'(exp_pe));
    chk("par_err_no_push", 32'(rxv_p), 32'd0);
    model_p(8'h07, 1'b1);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("par_ok_count", 32'(ppe_cnt), 32'(exp_pe));
    read_chk(1'b1, "par_ok_data");
    for (int k = 0; k < 3; k++) begin
      d  = 8'($urandom);
      pb = 1'($urandom);
      model_p(d, pb);
      send_frame(1'b1, d, 1'b1, pb, 1'b1);
    end
    repeat (3) @(posedge clk); #1;
    chk("par_rand_perr", 32'(ppe_cnt), 32'(exp_pe));
    chk("par_no_ferr", 32'(pfe_cnt), 32'd0);
    while (qp.size() > 0) read_chk(1'b1, "par_rand_data");

    // reset mid-frame with a byte already buffered
    d = 8'($urandom);
    model_a(d, 1'b1);
    send_frame(1'b0, d, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("pre_rst_valid", 32'(rxv_a), 32'd1);
    @(posedge clk); #1;
    fork
      send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
      begin
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        chk("mid_rst_valid", 32'(rxv_a), 32'd0);
        chk("mid_rst_data", 32'(rxd_a), 32'd0);
      end
    join
    reset = 1'b1;
    qa.delete();
    repeat (4) @(posedge clk); #1;
    model_a(8'h5A, 1'b1);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("post_rst_ferr", 32'(fe_cnt), 32'(exp_fe));
    chk("post_rst_perr", 32'(pe_cnt), 32'd0);
    read_chk(1'b0, "post_rst_data");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
